uart_line_editor: RTL and testbench

Line-editing consumer that sits directly downstream of the UART receive FIFO and upstream of the UART transmit FIFO in the typewriter design. It pops received characters and stores printable ones in a line buffer. It echoes each accepted character, applies backspace/delete editing, and terminates lines on carriage return. Completed-line status and the buffer contents are exposed to board logic (LEDs, seven-segment).

---
 rtl/uart_line_editor.sv | 160 ++++++++++++++++
 tb/tb_uart_line_editor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_editor.sv
// Line editor between the UART RX and TX FIFOs: pops characters, echoes and stores
// printable ones, applies backspace/delete editing and reports completed lines.
module uart_line_editor #(
   parameter  int TRANSMITTED_BITS = 8,
   parameter  int LINE_DEPTH       = 16,
   localparam int LW               = $clog2(LINE_DEPTH + 1),
   localparam int AW               = $clog2(LINE_DEPTH)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        rx_data_present,
   input  logic [TRANSMITTED_BITS-1:0] rx_data,
   output logic                        read_from_uart,
   input  logic                        tx_full,
   output logic [TRANSMITTED_BITS-1:0] tx_data,
   output logic                        write_to_uart,
   input  logic [AW-1:0]               rd_addr,
   output logic [TRANSMITTED_BITS-1:0] rd_data,
   output logic [LW-1:0]               line_length,
   output logic [LW-1:0]               last_length,
   output logic [TRANSMITTED_BITS-1:0] last_char,
   output logic                        line_done
);

   typedef logic [TRANSMITTED_BITS-1:0] char_t;
   typedef enum logic [1:0] {IDLE, DECODE, SEND, GAP} state_e;

   localparam char_t CH_NUL   = '0;
   localparam char_t CH_BEL   = char_t'(8'h07);
   localparam char_t CH_BS    = char_t'(8'h08);
   localparam char_t CH_LF    = char_t'(8'h0A);
   localparam char_t CH_CR    = char_t'(8'h0D);
   localparam char_t CH_SPACE = char_t'(8'h20);
   localparam char_t CH_TILDE = char_t'(8'h7E);
   localparam char_t CH_DEL   = char_t'(8'h7F);
   localparam logic [LW-1:0] DEPTH_LW = LW'(LINE_DEPTH);

   state_e                    state_q, state_d;
   char_t                     char_q, char_d;
   char_t                     last_char_q, last_char_d;
   char_t                     tx_data_q, tx_data_d;
   char_t                     rd_data_q;
   logic [LW-1:0]             line_length_q, line_length_d;
   logic [LW-1:0]             last_length_q, last_length_d;
   logic [2:0][TRANSMITTED_BITS-1:0] seq_q, seq_d;
   logic [1:0]                seq_cnt_q, seq_cnt_d;
   logic [1:0]                idx_q, idx_d;
   logic                      mem_we;

   char_t line_mem [LINE_DEPTH];

   always_comb begin
      // NOTE: every _d starts from its _q value so no path leaves a signal unassigned (no latches).
      state_d       = state_q;
      char_d        = char_q;
      last_char_d   = last_char_q;
      tx_data_d     = tx_data_q;
      line_length_d = line_length_q;
      last_length_d = last_length_q;
      seq_d         = seq_q;
      seq_cnt_d     = seq_cnt_q;
      idx_d         = idx_q;
      mem_we        = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_data_present) begin
               char_d      = rx_data;
               last_char_d = rx_data;
               state_d     = DECODE;
            end
         end
         DECODE: begin
            state_d   = SEND;
            idx_d     = '0;
            seq_cnt_d = 2'd1;
            seq_d     = {CH_NUL, CH_NUL, CH_BEL};
            if (char_q >= CH_SPACE && char_q <= CH_TILDE) begin
               if (line_length_q < DEPTH_LW) begin
                  mem_we        = 1'b1;
                  line_length_d = line_length_q + LW'(1);
                  seq_d         = {CH_NUL, CH_NUL, char_q};
               end
            end else if (char_q == CH_BS || char_q == CH_DEL) begin
               if (line_length_q != '0) begin
                  line_length_d = line_length_q - LW'(1);
                  seq_d         = {CH_BS, CH_SPACE, CH_BS};
                  seq_cnt_d     = 2'd3;
               end
            end else if (char_q == CH_CR) begin
               last_length_d = line_length_q;
               line_length_d = '0;
               seq_d         = {CH_NUL, CH_LF, CH_CR};
               seq_cnt_d     = 2'd2;
            end else begin
               state_d   = IDLE;
               seq_d     = seq_q;
               seq_cnt_d = seq_cnt_q;
            end
            tx_data_d = (state_d == SEND) ? seq_d[0] : tx_data_q;
         end
         SEND: begin
            if (!tx_full) state_d = GAP;
         end
         GAP: begin
            if ((idx_q + 2'd1) < seq_cnt_q) begin
               idx_d     = idx_q + 2'd1;
               tx_data_d = seq_q[idx_q + 2'd1];
               state_d   = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (!reset) begin
         state_q       <= IDLE;
         char_q        <= '0;
         last_char_q   <= '0;
         tx_data_q     <= '0;
         rd_data_q     <= '0;
         line_length_q <= '0;
         last_length_q <= '0;
         seq_q         <= '0;
         seq_cnt_q     <= '0;
         idx_q         <= '0;
      end else begin
         state_q       <= state_d;
         char_q        <= char_d;
         last_char_q   <= last_char_d;
         tx_data_q     <= tx_data_d;
         rd_data_q     <= line_mem[rd_addr];
         line_length_q <= line_length_d;
         last_length_q <= last_length_d;
         seq_q         <= seq_d;
         seq_cnt_q     <= seq_cnt_d;
         idx_q         <= idx_d;
      end
   end

   // NOTE: the line buffer is deliberately not reset; stale characters stay readable.
   always_ff @(posedge clock) begin
      if (reset && mem_we) line_mem[line_length_q[AW-1:0]] <= char_q;
   end

   // Strobes are decoded from the state so they fall in the same cycle as the decision.
   assign read_from_uart = (state_q == IDLE) && rx_data_present;
   assign write_to_uart  = (state_q == SEND) && !tx_full;
   assign line_done      = (state_q == DECODE) && (char_q == CH_CR);
   assign tx_data        = tx_data_q;
   assign rd_data        = rd_data_q;
   assign line_length    = line_length_q;
   assign last_length    = last_length_q;
   assign last_char      = last_char_q;

endmodule

// File: tb/tb_uart_line_editor.sv
// Directed and randomized bench for uart_line_editor, checked against a queue-based
// model of the line (stored characters, expected echo stream, completed lines).
module tb_uart_line_editor;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam int AW    = $clog2(DEPTH);

   logic          clock;
   logic          reset;
   logic          rx_data_present;
   logic [7:0]    rx_data;
   logic          read_from_uart;
   logic          tx_full;
   logic [7:0]    tx_data;
   logic          write_to_uart;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [LW-1:0] line_length;
   logic [LW-1:0] last_length;
   logic [7:0]    last_char;
   logic          line_done;

   uart_line_editor #(.TRANSMITTED_BITS(8), .LINE_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .rx_data_present(rx_data_present), .rx_data(rx_data), .read_from_uart(read_from_uart),
      .tx_full(tx_full), .tx_data(tx_data), .write_to_uart(write_to_uart),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .line_length(line_length), .last_length(last_length),
      .last_char(last_char), .line_done(line_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;
   int overlap   = 0;

   logic [7:0] rx_q [$];
   logic [7:0] tx_log [$];
   int         tx_cyc [$];
   int         pop_cyc [$];
   int         done_cyc [$];

   // Reference model of the line editor's visible behaviour.
   logic [7:0] line_m [DEPTH];
   int         len_m;
   int         last_len_m;
   logic [7:0] last_char_m;
   logic [7:0] exp_tx [$];
   int         exp_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void refresh_rx();
      rx_data_present = (rx_q.size() != 0);
      rx_data         = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
   endfunction

   function automatic void model_char(input logic [7:0] c);
      last_char_m = c;
      if (c >= 8'h20 && c <= 8'h7E) begin
         if (len_m < DEPTH) begin
            line_m[len_m] = c;
            len_m++;
            exp_tx.push_back(c);
         end else begin
            exp_tx.push_back(8'h07);
         end
      end else if (c == 8'h08 || c == 8'h7F) begin
         if (len_m > 0) begin
            len_m--;
            exp_tx.push_back(8'h08);
            exp_tx.push_back(8'h20);
            exp_tx.push_back(8'h08);
         end else begin
            exp_tx.push_back(8'h07);
         end
      end else if (c == 8'h0D) begin
         last_len_m = len_m;
         len_m      = 0;
         exp_done++;
         exp_tx.push_back(8'h0D);
         exp_tx.push_back(8'h0A);
      end
   endfunction

   function automatic void model_reset();
      len_m       = 0;
      last_len_m  = 0;
      last_char_m = 8'h00;
   endfunction

   function automatic void clear_logs();
      tx_log.delete();
      tx_cyc.delete();
      pop_cyc.delete();
      done_cyc.delete();
      exp_tx.delete();
      exp_done = 0;
   endfunction

   // One clock: sample outputs on the falling edge, update the RX FIFO model after the rising edge.
   task automatic tick();
      logic pop;
      @(negedge clock);
      cyc++;
      pop = read_from_uart;
      if (read_from_uart && write_to_uart) overlap++;
      if (write_to_uart) begin
         tx_log.push_back(tx_data);
         tx_cyc.push_back(cyc);
      end
      if (pop) pop_cyc.push_back(cyc);
      if (line_done) done_cyc.push_back(cyc);
      @(posedge clock);
      #1;
      if (pop && rx_q.size() != 0) void'(rx_q.pop_front());
      refresh_rx();
   endtask

   task automatic push(input logic [7:0] c);
      rx_q.push_back(c);
      model_char(c);
      refresh_rx();
   endtask

   task automatic settle(input int budget);
      int idle = 0;
      int n    = 0;
      int ntx;
      int npop;
      while (idle < 8 && n < budget) begin
         ntx  = tx_log.size();
         npop = pop_cyc.size();
         tick();
         n++;
         if (tx_log.size() != ntx || pop_cyc.size() != npop || rx_q.size() != 0) idle = 0;
         else idle++;
      end
      check("settle_in_budget", 32'(idle >= 8), 1);
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
         check($sformatf("%s_tx%0d", tag, i), tx_log[i], exp_tx[i]);
   endtask

   task automatic read_buf(input int addr, input logic [7:0] exp, input string tag);
      rd_addr = AW'(addr);
      tick();
      check(tag, rd_data, exp);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_read"},        read_from_uart, 0);
      check({tag, "_write"},       write_to_uart,  0);
      check({tag, "_tx_data"},     tx_data,        0);
      check({tag, "_line_length"}, line_length,    0);
      check({tag, "_last_length"}, last_length,    0);
      check({tag, "_last_char"},   last_char,      0);
      check({tag, "_line_done"},   line_done,      0);
      check({tag, "_rd_data"},     rd_data,        0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c;
      int         n;

      reset   = 1'b0;
      tx_full = 1'b0;
      rd_addr = '0;
      refresh_rx();
      model_reset();
      exp_done = 0;

      // Reset state
      tick();
      tick();
      check_reset_values("reset");
      reset = 1'b1;
      clear_logs();

      // Single printable character: pop, echo two cycles later, store
      push(8'h41);
      settle(200);
      compare_stream("echo_A");
      check("A_pop_count", pop_cyc.size(), 1);
      if (pop_cyc.size() == 1 && tx_cyc.size() == 1)
         check("A_pop_to_write", tx_cyc[0] - pop_cyc[0], 2);
      check("A_line_length", line_length, 1);
      check("A_last_char", last_char, 8'h41);
      read_buf(0, 8'h41, "A_buf0");

      // Editing: "HI", BS, DEL, then BS on an empty line
      clear_logs();
      push(8'h48); push(8'h49); push(8'h08); push(8'h7F); push(8'h08);
      settle(400);
      compare_stream("edit");
      check("edit_line_length", line_length, len_m);
      check("edit_pop_count", pop_cyc.size(), 5);
      if (pop_cyc.size() == 5) begin
         check("edit_pop_gap_1byte", pop_cyc[1] - pop_cyc[0], 4);
         check("edit_pop_gap_3byte", pop_cyc[3] - pop_cyc[2], 8);
      end
      if (tx_cyc.size() >= 5) begin
         check("edit_bs_spacing_a", tx_cyc[3] - tx_cyc[2], 2);
         check("edit_bs_spacing_b", tx_cyc[4] - tx_cyc[3], 2);
      end

      // Fill the line past capacity
      clear_logs();
      for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom_range(32'h20, 32'h7E)));
      settle(1000);
      compare_stream("fill");
      check("fill_line_length", line_length, DEPTH);
      for (int i = 0; i < DEPTH; i++) read_buf(i, line_m[i], $sformatf("fill_buf%0d", i));
      clear_logs();
      push(8'h08);
      settle(200);
      compare_stream("fill_bs");
      check("fill_bs_line_length", line_length, DEPTH - 1);
      read_buf(DEPTH - 1, line_m[DEPTH - 1], "stale_buf_after_bs");

      // Randomized mix of printable, editing, CR and arbitrary codes
      clear_logs();
      for (int i = 0; i < 40; i++) begin
         n = int'($urandom_range(0, 9));
         if (n <= 5)      c = 8'($urandom_range(32'h20, 32'h7E));
         else if (n == 6) c = 8'h08;
         else if (n == 7) c = 8'h7F;
         else if (n == 8) c = 8'h0D;
         else             c = 8'($urandom);
         push(c);
      end
      settle(4000);
      compare_stream("mix");
      check("mix_line_length", line_length, len_m);
      check("mix_last_length", last_length, last_len_m);
      check("mix_last_char", last_char, last_char_m);
      check("mix_line_done_count", done_cyc.size(), exp_done);
      check("mix_pop_count", pop_cyc.size(), 40);

      // Line termination: "OK" + CR from a fresh line
      reset = 1'b0;
      tick();
      reset = 1'b1;
      model_reset();
      clear_logs();
      push(8'h4F); push(8'h4B); push(8'h0D);
      settle(300);
      compare_stream("ok_cr");
      check("ok_last_length", last_length, 2);
      check("ok_line_length", line_length, 0);
      check("ok_line_done_count", done_cyc.size(), 1);
      if (done_cyc.size() == 1 && pop_cyc.size() == 3)
         check("ok_line_done_in_decode", done_cyc[0] - pop_cyc[2], 1);
      read_buf(1, 8'h4B, "ok_buf1");

      // Backpressure: tx_full held across a CR sequence, with another character waiting
      clear_logs();
      tx_full = 1'b1;
      push(8'h0D);
      push(8'h5A);
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("hold_tx_data%0d", i), tx_data, 8'h0D);
      end
      check("hold_no_write", tx_log.size(), 0);
      check("hold_single_pop", pop_cyc.size(), 1);
      tx_full = 1'b0;
      settle(300);
      compare_stream("hold");
      if (tx_cyc.size() >= 2) check("hold_gap_cycle", tx_cyc[1] - tx_cyc[0], 2);
      if (tx_cyc.size() >= 2 && pop_cyc.size() >= 2)
         check("hold_next_pop_after_seq", pop_cyc[1] - tx_cyc[1], 2);
      check("hold_last_length", last_length, last_len_m);

      // Reset between the first and second byte of a backspace echo
      clear_logs();
      push(8'h51);
      settle(200);
      clear_logs();
      push(8'h08);
      n = 0;
      while (tx_log.size() == 0 && n < 50) begin
         tick();
         n++;
      end
      check("mid_bs_first_byte", tx_log.size(), 1);
      if (tx_log.size() == 1) check("mid_bs_first_value", tx_log[0], 8'h08);
      reset = 1'b0;
      tick();
      model_reset();
      check_reset_values("mid_reset");
      reset = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("mid_reset_no_more_writes", tx_log.size(), 1);
      clear_logs();
      push(8'h52);
      settle(200);
      compare_stream("after_reset");
      check("after_reset_line_length", line_length, 1);
      read_buf(0, 8'h52, "after_reset_buf0");

      check("strobe_overlap", overlap, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
